// File: rtl/systolic_array_sequencer_if.sv
// Handshake/bus bundle between the layer control FSM, the tile sequencer and the
// operand buffers.
interface systolic_array_sequencer_if #(
    parameter int unsigned ARRAY_N = 4,
    parameter int unsigned ADDR_W  = 4
);
    logic                        start;
    logic                        abort;
    logic [ADDR_W:0]             k_len;
    logic                        busy;
    logic                        done;
    logic                        err;
    logic                        pe_clear;
    logic [ARRAY_N-1:0]          row_rd_en;
    logic [ARRAY_N*ADDR_W-1:0]   row_rd_addr;
    logic [ARRAY_N-1:0]          col_rd_en;
    logic [ARRAY_N*ADDR_W-1:0]   col_rd_addr;
    logic                        result_valid;

    modport master (
        output start, abort, k_len,
        input  busy, done, err, pe_clear, row_rd_en, row_rd_addr,
               col_rd_en, col_rd_addr, result_valid
    );

    modport slave (
        input  start, abort, k_len,
        output busy, done, err, pe_clear, row_rd_en, row_rd_addr,
               col_rd_en, col_rd_addr, result_valid
    );
endinterface

// File: rtl/systolic_array_sequencer.sv
// Sequences one output-stationary N x N systolic tile: clear, diagonally skewed
// operand feed, pipeline drain, completion strobe. All outputs are registered.
module systolic_array_sequencer #(
    parameter int unsigned ARRAY_N = 4,
    parameter int unsigned K_MAX   = 16,
    parameter int unsigned ADDR_W  = 4,
    parameter int unsigned RD_LAT  = 1
) (
    input  logic                          clk,
    input  logic                          reset,
    systolic_array_sequencer_if.slave     bus
);
    localparam int unsigned K_W   = ADDR_W + 1;
    localparam int unsigned CNT_W = $clog2(K_MAX + ARRAY_N + RD_LAT + 1);
    localparam int unsigned VEC_W = ARRAY_N * ADDR_W;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_FEED,
        ST_DRAIN,
        ST_DONE
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   t_q, t_d;
    logic [K_W-1:0]     k_q, k_d;

    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               err_q, err_d;
    logic               pe_clear_q, pe_clear_d;
    logic               result_valid_q, result_valid_d;
    logic [ARRAY_N-1:0] row_rd_en_q, row_rd_en_d;
    logic [ARRAY_N-1:0] col_rd_en_q, col_rd_en_d;
    logic [VEC_W-1:0]   row_rd_addr_q, row_rd_addr_d;
    logic [VEC_W-1:0]   col_rd_addr_q, col_rd_addr_d;

    logic               k_valid_c;
    logic [CNT_W-1:0]   feed_last_c;
    logic [CNT_W-1:0]   drain_last_c;

    assign k_valid_c    = (bus.k_len != '0) && (bus.k_len <= K_W'(K_MAX));
    assign feed_last_c  = CNT_W'(k_q) + CNT_W'(ARRAY_N - 2);
    assign drain_last_c = CNT_W'(ARRAY_N + RD_LAT - 1);

    // Next state, then outputs decoded from the next state so they register alongside it.
    always_comb begin
        state_d        = state_q;
        t_d            = t_q;
        k_d            = k_q;
        busy_d         = 1'b0;
        done_d         = 1'b0;
        err_d          = 1'b0;
        pe_clear_d     = 1'b0;
        result_valid_d = 1'b0;
        row_rd_en_d    = '0;
        row_rd_addr_d  = '0;

        unique case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    if (k_valid_c) begin
                        k_d     = bus.k_len;
                        t_d     = '0;
                        state_d = ST_CLEAR;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            ST_CLEAR: begin
                t_d     = '0;
                state_d = ST_FEED;
            end
            ST_FEED: begin
                if (t_q == feed_last_c) begin
                    t_d     = '0;
                    state_d = ST_DRAIN;
                end else begin
                    t_d = t_q + CNT_W'(1);
                end
            end
            ST_DRAIN: begin
                if (t_q == drain_last_c) begin
                    t_d     = '0;
                    state_d = ST_DONE;
                end else begin
                    t_d = t_q + CNT_W'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (bus.abort && (state_q != ST_IDLE)) begin
            state_d = ST_IDLE;
            t_d     = '0;
        end

        busy_d         = (state_d != ST_IDLE);
        pe_clear_d     = (state_d == ST_CLEAR);
        done_d         = (state_d == ST_DONE);
        result_valid_d = (state_d == ST_DONE);

        // Row/column i sees its k operands starting i cycles late (diagonal skew).
        if (state_d == ST_FEED) begin
            for (int i = 0; i < ARRAY_N; i++) begin
                if ((t_d >= CNT_W'(i)) && (t_d < (CNT_W'(i) + CNT_W'(k_d)))) begin
                    row_rd_en_d[i]                   = 1'b1;
                    row_rd_addr_d[i*ADDR_W +: ADDR_W] = ADDR_W'(t_d - CNT_W'(i));
                end
            end
        end

        col_rd_en_d   = row_rd_en_d;
        col_rd_addr_d = row_rd_addr_d;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q        <= ST_IDLE;
            t_q            <= '0;
            k_q            <= '0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            err_q          <= 1'b0;
            pe_clear_q     <= 1'b0;
            result_valid_q <= 1'b0;
            row_rd_en_q    <= '0;
            col_rd_en_q    <= '0;
            row_rd_addr_q  <= '0;
            col_rd_addr_q  <= '0;
        end else begin
            state_q        <= state_d;
            t_q            <= t_d;
            k_q            <= k_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
            err_q          <= err_d;
            pe_clear_q     <= pe_clear_d;
            result_valid_q <= result_valid_d;
            row_rd_en_q    <= row_rd_en_d;
            col_rd_en_q    <= col_rd_en_d;
            row_rd_addr_q  <= row_rd_addr_d;
            col_rd_addr_q  <= col_rd_addr_d;
        end
    end

    assign bus.busy         = busy_q;
    assign bus.done         = done_q;
    assign bus.err          = err_q;
    assign bus.pe_clear     = pe_clear_q;
    assign bus.result_valid = result_valid_q;
    assign bus.row_rd_en    = row_rd_en_q;
    assign bus.col_rd_en    = col_rd_en_q;
    assign bus.row_rd_addr  = row_rd_addr_q;
    assign bus.col_rd_addr  = col_rd_addr_q;
endmodule

// File: doc/systolic_array_sequencer.md
Name: systolic_array_sequencer

Overview:
- Sequences one N×N output-stationary systolic array of MAC elements through one matrix-multiply tile: clear accumulators, skewed operand feed, pipeline drain, completion.
- Generates per-row A-buffer and per-column B-buffer read enables and addresses with the diagonal skew the array needs.
- Sits between the layer control FSM (start/abort/done) and the operand buffers and PE array.

Parameters:
- ARRAY_N, 4, rows = columns of the PE array (≥2)
- K_MAX, 16, maximum inner dimension (tile depth) supported
- ADDR_W, 4, operand buffer address width; K_MAX ≤ 2^ADDR_W
- RD_LAT, 1, operand buffer read latency in cycles (1 or 2)

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- start  in  1  request a tile; sampled only in IDLE
- abort  in  1  cancel the current tile
- k_len  in  ADDR_W+1  inner dimension for this tile, legal 1..K_MAX
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse on tile completion
- err  out  1  one-cycle pulse when start is rejected
- pe_clear  out  1  synchronous accumulator clear to the array
- row_rd_en  out  ARRAY_N  A-buffer read enable per array row
- row_rd_addr  out  ARRAY_N*ADDR_W  A-buffer address per row; row i is bits [i*ADDR_W +: ADDR_W]
- col_rd_en  out  ARRAY_N  B-buffer read enable per array column
- col_rd_addr  out  ARRAY_N*ADDR_W  B-buffer address per column, same packing
- result_valid  out  1  one-cycle strobe: array outputs hold the final tile result

Behaviour:
- Reset is reset, asynchronous, active-low; clock is clk.
- During reset: state=IDLE and all outputs 0 (addresses 0, enables 0, strobes 0).
- All outputs are registered; no combinational path from any input to any output.
- States: IDLE, CLEAR, FEED, DRAIN, DONE.
- IDLE:
  - start=1 with 1 ≤ k_len ≤ K_MAX: latch k_len into k_r, go to CLEAR.
  - start=1 with k_len=0 or k_len>K_MAX: err=1 for one cycle, stay in IDLE.
- CLEAR: one cycle.
  - pe_clear=1; enables 0.
  - Go to FEED with t=0.
- FEED: lasts k_r+ARRAY_N-1 cycles, t=0..k_r+ARRAY_N-2.
  - Row i: row_rd_en[i]=1 iff i ≤ t < i+k_r; row_rd_addr[i]=t−i when enabled, else 0.
  - Column j: same rule with j.
  - Leave FEED after t=k_r+ARRAY_N-2.
- DRAIN: ARRAY_N+RD_LAT cycles.
  - All enables 0; addresses 0.
  - Lets the last operands reach PE(N-1,N-1).
- DONE: one cycle.
  - done=1 and result_valid=1 together.
  - busy=1 in this cycle.
  - Next state IDLE.
- Latency: the done cycle is k_len+2·ARRAY_N+RD_LAT+1 cycles after the clock edge that samples start. Example: N=4, k=4, RD_LAT=1 gives 14.
- start while busy: ignored; no err. k_len changes while busy have no effect.
- abort=1 in any non-IDLE state, including DONE: the next state is IDLE.
  - All outputs 0 next cycle; done and result_valid are not asserted.
  - abort in IDLE is ignored; abort has priority over start.
- Reset asserted mid-tile: immediate return to the reset state; no done.
- k_r=K_MAX: addresses reach K_MAX−1 with no wrap; t counter width must hold K_MAX+ARRAY_N−2.
- Back-to-back tiles: start may be asserted in the first IDLE cycle after DONE, giving a minimum gap of 1 idle cycle.

Test Plan:
- N=4, RD_LAT=1, start with k_len=4 → pe_clear high on cycle 1; row_rd_en[0] high on cycles 2–5 with addresses 0,1,2,3; row_rd_en[3] high on cycles 5–8 with addresses 0–3; done and result_valid high on cycle 14 only.
- k_len=1 → each row and column enable is high for exactly 1 cycle with address 0, staggered by 1 cycle per index; done on cycle 11.
- k_len=16 (K_MAX) → row 3 addresses run 0..15 with no wrap; done on cycle 26. Then k_len=0 and k_len=17 → err pulses, busy stays 0, no pe_clear.
- abort during FEED at cycle 4 of a k_len=8 tile → cycle 5 is IDLE with all enables 0; no done. A new start next cycle completes normally.
- start pulsed during DRAIN with k_len=3 → ignored; only one done. Start held high across DONE → the second tile begins from the first IDLE cycle.
- reset driven low mid-FEED asynchronously → outputs go to 0 before the next clk edge. After release, start with k_len=2 produces done on cycle 12.
